// File: rtl/bp_be_fe_cmd_arbiter.sv
// bp_be_fe_cmd_arbiter
// Fixed-priority merge of BE-side FE command producers onto the single FE
// command channel. The winning command is registered, held until the FE
// accepts it, and a fence-class command stalls all issue until the FE
// reports that the fence has drained.
module bp_be_fe_cmd_arbiter #(
    parameter int num_req_p   = 4,
    parameter int cmd_width_p = 64,
    parameter int cnt_width_p = 16
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_req_p-1:0]             req_v_i,
    input  logic [num_req_p*cmd_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]             req_fence_i,
    output logic [num_req_p-1:0]             req_yumi_o,
    output logic [cmd_width_p-1:0]           fe_cmd_o,
    output logic                             fe_cmd_v_o,
    input  logic                             fe_cmd_ready_i,
    input  logic                             fe_cmd_fence_i,
    output logic                             busy_o,
    output logic [cnt_width_p-1:0]           cmd_cnt_o
);

    localparam int idx_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FENCE = 2'd2
    } state_e;

    state_e                 state_r;
    logic [cmd_width_p-1:0] fe_cmd_r;
    logic                   fe_cmd_v_r;
    logic                   out_fence_r;
    logic                   busy_r;
    logic [cnt_width_p-1:0] cnt_r;

    logic                   accept_s;
    logic                   can_grant_s;
    logic                   any_req_s;
    logic                   grant_s;
    logic [idx_w_lp-1:0]    grant_idx_s;
    logic [num_req_p-1:0]   req_yumi_s;
    logic [cmd_width_p-1:0] sel_cmd_s;
    logic                   sel_fence_s;

    assign accept_s    = fe_cmd_v_r & fe_cmd_ready_i;
    assign can_grant_s = (state_r == IDLE) |
                         ((state_r == SEND) & accept_s & ~out_fence_r);
    assign any_req_s   = |req_v_i;
    // Reset gating keeps requesters from dequeuing while the block is held in reset.
    assign grant_s     = can_grant_s & any_req_s & reset_n_i;
    assign sel_cmd_s   = req_cmd_i[grant_idx_s*cmd_width_p +: cmd_width_p];
    assign sel_fence_s = req_fence_i[grant_idx_s];

    // Priority encoder: scanning from the top down leaves the lowest valid index.
    always_comb begin
        grant_idx_s = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            grant_idx_s = req_v_i[i] ? idx_w_lp'(i) : grant_idx_s;
        end
    end

    // One-hot dequeue strobe toward the winning requester.
    always_comb begin
        req_yumi_s = '0;
        if (grant_s) begin
            req_yumi_s[grant_idx_s] = 1'b1;
        end else begin
            req_yumi_s = '0;
        end
    end

    // Control FSM with the output command register and accept counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            fe_cmd_r    <= '0;
            fe_cmd_v_r  <= 1'b0;
            out_fence_r <= 1'b0;
            busy_r      <= 1'b0;
            cnt_r       <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        fe_cmd_r    <= sel_cmd_s;
                        out_fence_r <= sel_fence_s;
                        fe_cmd_v_r  <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= SEND;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                SEND: begin
                    if (accept_s) begin
                        cnt_r <= cnt_r + cnt_width_p'(1);
                        if (out_fence_r) begin
                            fe_cmd_v_r <= 1'b0;
                            state_r    <= FENCE;
                        end else if (grant_s) begin
                            fe_cmd_r    <= sel_cmd_s;
                            out_fence_r <= sel_fence_s;
                            state_r     <= SEND;
                        end else begin
                            fe_cmd_v_r <= 1'b0;
                            busy_r     <= 1'b0;
                            state_r    <= IDLE;
                        end
                    end else begin
                        state_r <= SEND;
                    end
                end
                FENCE: begin
                    if (!fe_cmd_fence_i) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= FENCE;
                    end
                end
                default: begin
                    fe_cmd_v_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign req_yumi_o = req_yumi_s;
    assign fe_cmd_o   = fe_cmd_r;
    assign fe_cmd_v_o = fe_cmd_v_r;
    assign busy_o     = busy_r;
    assign cmd_cnt_o  = cnt_r;

endmodule

// File: tb/tb_bp_be_fe_cmd_arbiter.sv
// Testbench for bp_be_fe_cmd_arbiter: directed scenarios plus a randomized
// phase, each cycle compared against a transaction-level reference model.
module tb_bp_be_fe_cmd_arbiter;

    localparam int NR = 4;
    localparam int CW = 64;
    localparam int KW = 16;

    logic              clk;
    logic              reset_n;
    logic [NR-1:0]     req_v;
    logic [NR*CW-1:0]  req_cmd;
    logic [NR-1:0]     req_fence;
    logic [NR-1:0]     req_yumi;
    logic [CW-1:0]     fe_cmd;
    logic              fe_cmd_v;
    logic              fe_cmd_ready;
    logic              fe_cmd_fence;
    logic              busy;
    logic [KW-1:0]     cmd_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: an output slot, a fence-wait flag and an accept count.
    bit          m_have;
    logic [63:0] m_cmd;
    bit          m_fence;
    bit          m_wait;
    int          m_cnt;
    int          v_cycles;

    bp_be_fe_cmd_arbiter #(.num_req_p(NR), .cmd_width_p(CW), .cnt_width_p(KW)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .req_v_i       (req_v),
        .req_cmd_i     (req_cmd),
        .req_fence_i   (req_fence),
        .req_yumi_o    (req_yumi),
        .fe_cmd_o      (fe_cmd),
        .fe_cmd_v_o    (fe_cmd_v),
        .fe_cmd_ready_i(fe_cmd_ready),
        .fe_cmd_fence_i(fe_cmd_fence),
        .busy_o        (busy),
        .cmd_cnt_o     (cmd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have  = 1'b0;
        m_cmd   = 64'd0;
        m_fence = 1'b0;
        m_wait  = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock cycle: check outputs against the model at the falling edge,
    // then advance the model by the rules and let the rising edge happen.
    task automatic step(input bit chk, input string tag);
        bit          acc;
        bit          may;
        int          win;
        logic [3:0]  exp_yumi;
        @(negedge clk);
        acc = m_have && fe_cmd_ready;
        may = (!m_have && !m_wait) || (acc && !m_fence);
        win = -1;
        for (int i = NR - 1; i >= 0; i--) begin
            if (req_v[i]) win = i;
        end
        exp_yumi = (may && win >= 0) ? (4'd1 << win) : 4'd0;
        if (fe_cmd_v) v_cycles++;
        if (chk) begin
            chk_eq({tag, ".yumi"}, 64'(req_yumi), 64'(exp_yumi));
            chk_eq({tag, ".v"},    64'(fe_cmd_v), 64'(m_have));
            chk_eq({tag, ".busy"}, 64'(busy),     64'(m_have || m_wait));
            chk_eq({tag, ".cnt"},  64'(cmd_cnt),  64'(m_cnt));
            if (m_have) chk_eq({tag, ".cmd"}, fe_cmd, m_cmd);
        end
        if (acc) m_cnt = (m_cnt + 1) % 65536;
        if (m_wait) begin
            if (!fe_cmd_fence) m_wait = 1'b0;
        end else if (acc && m_fence) begin
            m_have = 1'b0;
            m_wait = 1'b1;
        end else if (acc || !m_have) begin
            if (exp_yumi != 4'd0) begin
                m_have  = 1'b1;
                m_cmd   = req_cmd[win*CW +: CW];
                m_fence = req_fence[win];
            end else begin
                m_have = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payloads();
        for (int i = 0; i < NR; i++) req_cmd[i*CW +: CW] = {$urandom, $urandom};
    endtask

    initial begin
        reset_n      = 1'b0;
        req_v        = 4'd0;
        req_cmd      = '0;
        req_fence    = 4'd0;
        fe_cmd_ready = 1'b0;
        fe_cmd_fence = 1'b0;
        v_cycles     = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        req_v = 4'b1111;
        #1;
        chk_eq("rst.v",    64'(fe_cmd_v), 64'd0);
        chk_eq("rst.cmd",  fe_cmd,        64'd0);
        chk_eq("rst.busy", 64'(busy),     64'd0);
        chk_eq("rst.cnt",  64'(cmd_cnt),  64'd0);
        chk_eq("rst.yumi", 64'(req_yumi), 64'd0);
        req_v   = 4'd0;
        reset_n = 1'b1;

        // Priority: requester 1 beats requester 3.
        rand_payloads();
        req_v = 4'b1010;
        #1;
        chk_eq("prio.yumi_const", 64'(req_yumi), 64'h2);
        step(1'b1, "prio0");
        req_v = 4'b0000;
        chk_eq("prio.cmd_const", fe_cmd, req_cmd[1*CW +: CW]);
        step(1'b1, "prio1");
        fe_cmd_ready = 1'b1;
        step(1'b1, "prio2");
        step(1'b1, "prio3");

        // Backpressure: slot 0 held five cycles, then accept plus regrant.
        fe_cmd_ready = 1'b0;
        req_v        = 4'b0001;
        step(1'b1, "bp_grant");
        for (int k = 0; k < 5; k++) step(1'b1, "bp_hold");
        fe_cmd_ready = 1'b1;
        step(1'b1, "bp_accept");
        req_v = 4'b0000;
        step(1'b1, "bp_drain");
        step(1'b1, "bp_idle");

        // Streaming: eight back-to-back commands from requester 2.
        v_cycles = 0;
        req_v    = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            req_cmd[2*CW +: CW] = {$urandom, $urandom};
            step(1'b1, "stream");
        end
        req_v = 4'b0000;
        step(1'b1, "stream_last");
        step(1'b1, "stream_idle");
        chk_eq("stream.vcycles", 64'(v_cycles), 64'd8);

        // Fence: stall until the FE reports the fence is done.
        req_v     = 4'b0001;
        req_fence = 4'b0001;
        step(1'b1, "fence_grant");
        req_fence    = 4'b0000;
        step(1'b1, "fence_accept");
        fe_cmd_fence = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1, "fence_wait");
        fe_cmd_fence = 1'b0;
        step(1'b1, "fence_exit");
        chk_eq("fence.no_early_v", 64'(fe_cmd_v), 64'd0);
        step(1'b1, "fence_regrant");
        chk_eq("fence.v_after", 64'(fe_cmd_v), 64'd1);
        req_v = 4'b0000;
        step(1'b1, "fence_drain");
        step(1'b1, "fence_idle");

        // Randomized phase.
        for (int k = 0; k < 400; k++) begin
            rand_payloads();
            req_v        = 4'($urandom_range(0, 15));
            req_fence    = 4'd0;
            for (int i = 0; i < NR; i++) req_fence[i] = ($urandom_range(0, 7) == 0);
            fe_cmd_ready = ($urandom_range(0, 3) != 0);
            fe_cmd_fence = ($urandom_range(0, 2) != 0);
            step(1'b1, "rand");
        end
        req_v        = 4'd0;
        req_fence    = 4'd0;
        fe_cmd_ready = 1'b1;
        fe_cmd_fence = 1'b0;
        for (int k = 0; k < 4; k++) step(1'b1, "rand_drain");

        // Counter wrap: stream until 65535 accepts, then one more.
        req_v = 4'b0100;
        for (int k = 0; k < 70000 && m_cnt != 65535; k++) step(1'b0, "wrap_fill");
        step(1'b1, "wrap_top");
        step(1'b1, "wrap_over");
        req_v = 4'b0000;
        chk_eq("wrap.cnt_zero", 64'(cmd_cnt), 64'(m_cnt));
        chk_eq("wrap.cnt_zero_const", 64'(cmd_cnt <= 16'd1), 64'd1);
        step(1'b1, "wrap_drain");
        step(1'b1, "wrap_idle");

        // Reset while a command is waiting for the FE.
        fe_cmd_ready = 1'b0;
        req_v        = 4'b0010;
        step(1'b1, "mid_grant");
        step(1'b1, "mid_hold");
        #2;
        reset_n = 1'b0;
        #1;
        chk_eq("mid_rst.v",    64'(fe_cmd_v), 64'd0);
        chk_eq("mid_rst.cnt",  64'(cmd_cnt),  64'd0);
        chk_eq("mid_rst.busy", 64'(busy),     64'd0);
        chk_eq("mid_rst.yumi", 64'(req_yumi), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk_eq("post_rst.yumi", 64'(req_yumi), 64'h2);
        step(1'b1, "post_rst");
        step(1'b1, "post_rst_v");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_be_fe_cmd_arbiter.md
# bp_be_fe_cmd_arbiter

Single-clock arbiter in the BE checker that merges FE command requests from several producers onto the one FE command channel. Producers include trap/interrupt redirect, branch-mispredict redirect, iTLB fill, and fence/satp writes. The block grants one requester per cycle by fixed priority and registers the winning command toward the FE. It holds that command until the FE accepts it. After a fence-class command it blocks all further issue until the FE reports that the fence has completed.

## Interface
Parameters:
- num_req_p, 4, number of requesters; index 0 has the highest priority.
- cmd_width_p, 64, width of one FE command payload.
- cnt_width_p, 16, width of the issued-command counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_v_i  in  num_req_p  per-requester command valid.
- req_cmd_i  in  num_req_p*cmd_width_p  per-requester payload; slot i occupies bits [i*cmd_width_p +: cmd_width_p].
- req_fence_i  in  num_req_p  per-requester flag: this command is fence-class.
- req_yumi_o  out  num_req_p  one-hot or zero; requester i is dequeued this cycle.
- fe_cmd_o  out  cmd_width_p  registered command toward the FE.
- fe_cmd_v_o  out  1  fe_cmd_o is valid.
- fe_cmd_ready_i  in  1  FE accepts fe_cmd_o this cycle when fe_cmd_v_o is also high.
- fe_cmd_fence_i  in  1  FE is still processing a fence-class command.
- busy_o  out  1  state is not IDLE.
- cmd_cnt_o  out  cnt_width_p  count of commands accepted by the FE; wraps.

## Operation
- States:
  - IDLE: output register empty.
  - SEND: fe_cmd_v_o=1, waiting for fe_cmd_ready_i.
  - FENCE: fence-class command accepted, waiting for the FE.
- Definitions:
  - accept = fe_cmd_v_o & fe_cmd_ready_i.
  - out_fence = stored fence flag of the current output command.
  - can_grant = (state==IDLE) | (state==SEND & accept & ~out_fence).
- Grant: if can_grant, select the lowest index i with req_v_i[i]=1.
  - req_yumi_o[i]=1 combinationally in the same cycle.
  - At the next edge, load req_cmd_i slot i and req_fence_i[i] into the output register.
  - If no requester is valid, req_yumi_o=0.
- Transitions:
  - IDLE -> SEND on grant.
  - SEND & accept & out_fence -> FENCE. No grant occurs in this cycle.
  - SEND & accept & ~out_fence -> SEND if granted, otherwise IDLE.
  - SEND & ~accept -> SEND. fe_cmd_o is held stable.
  - FENCE & ~fe_cmd_fence_i -> IDLE.
  - FENCE & fe_cmd_fence_i -> FENCE.
- No grant is made in FENCE, including the exit cycle. The earliest next grant is the cycle after the block returns to IDLE.
- cmd_cnt_o increments by 1 on every accept, modulo 2^cnt_width_p.
- A requester that is not granted keeps req_v_i asserted. The arbiter does not store losers.
- Fixed priority: starvation of high-index requesters is permitted by design.
- Reset: asynchronous assertion forces the following immediately, including mid-handshake or mid-fence; an in-flight command is dropped.
  - state = IDLE.
  - fe_cmd_v_o = 0.
  - fe_cmd_o = 0.
  - stored fence flag = 0.
  - cmd_cnt_o = 0.
  - busy_o = 0.
  - req_yumi_o = 0 while reset_n_i is low.

## Timing
- Grant-to-valid latency: 1 cycle (yumi in cycle N, fe_cmd_v_o high in cycle N+1).
- Throughput: 1 command per cycle for back-to-back non-fence commands with fe_cmd_ready_i held high.
- req_yumi_o depends combinationally on req_v_i, state and fe_cmd_ready_i. There is no combinational path from req_cmd_i to any output.
- fe_cmd_o and fe_cmd_v_o are outputs of flops only.
- FENCE occupies at least 1 cycle after a fence accept. fe_cmd_fence_i is first sampled in the cycle after accept.
- Simultaneous accept of a fence command and req_v_i: no yumi. The requester waits until FENCE exits.
- Reset deassertion: the first grant is possible in the first cycle after reset_n_i is sampled high.

## Test plan
- Priority: req_v_i=4'b1010 in IDLE -> req_yumi_o=4'b0010. Next cycle fe_cmd_o = slot 1 payload, fe_cmd_v_o=1.
- Backpressure: hold fe_cmd_ready_i=0 for 5 cycles with req_v_i=4'b0001 -> fe_cmd_o stable, req_yumi_o=0 throughout. Raise ready -> accept, cmd_cnt_o 0->1, and slot 0 is granted in the same cycle.
- Streaming: 8 non-fence commands from requester 2 with ready=1 -> 8 consecutive fe_cmd_v_o cycles, cmd_cnt_o=8.
- Fence: accept a fence command, then hold fe_cmd_fence_i=1 for 3 cycles with req_v_i=4'b0001 -> busy_o=1, no yumi for 4 cycles. Next fe_cmd_v_o occurs 2 cycles after fe_cmd_fence_i falls.
- Wrap: preset 65535 accepts (cnt_width_p=16), then one more -> cmd_cnt_o=0.
- Reset mid-operation: assert reset_n_i=0 while in SEND -> fe_cmd_v_o=0, cmd_cnt_o=0, busy_o=0 asynchronously. After release, the first grant is observed.
